flash_exerciser: RTL and testbench

//  Parametrised self-checking traffic generator for the SPI flash controller request port (en/write/addr/data/ready).

---
 rtl/flash_exerciser_pkg.sv | 29 ++
 rtl/flash_pattern_gen.sv | 58 +++++
 rtl/flash_exerciser.sv | 182 ++++++++++++++++++
 tb/tb_flash_exerciser.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_exerciser_pkg.sv
// Shared encodings for the SPI flash traffic exerciser.
package flash_exerciser_pkg;

  typedef enum logic [1:0] {
    MODE_WV     = 2'd0,
    MODE_VERIFY = 2'd1,
    MODE_WRITE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_CONST = 2'd2,
    PAT_NADDR = 2'd3
  } pattern_sel_t;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WR   = 4'd1,
    ST_RD   = 4'd2,
    ST_CHK  = 4'd3,
    ST_DONE = 4'd4
  } state_t;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (left-shifting form)
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

endpackage

// File: rtl/flash_pattern_gen.sv
// Data pattern generator shared by the write and verify phases.
module flash_pattern_gen
  import flash_exerciser_pkg::*;
#(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              rewind,
  input  logic              step,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] POLY = DATA_W'(LFSR_POLY);

  pattern_sel_t      sel_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] lfsr_q;

  // An all-zero LFSR would lock up, so a zero seed starts from 1
  function automatic logic [DATA_W-1:0] nonzero(input logic [DATA_W-1:0] s);
    return (s == '0) ? DATA_W'(1) : s;
  endfunction

  // Seed/selection capture and one LFSR step per word
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q  <= PAT_ADDR;
      seed_q <= '0;
      lfsr_q <= DATA_W'(1);
    end else if (load) begin
      sel_q  <= pattern_sel_t'(sel);
      seed_q <= seed;
      lfsr_q <= nonzero(seed);
    end else if (rewind) begin
      lfsr_q <= nonzero(seed_q);
    end else if (step) begin
      lfsr_q <= {lfsr_q[DATA_W-2:0], 1'b0} ^ (lfsr_q[DATA_W-1] ? POLY : '0);
    end
  end

  // Pattern word for the current address
  always_comb begin
    data = DATA_W'(addr);
    case (sel_q)
      PAT_LFSR:  data = lfsr_q;
      PAT_CONST: data = seed_q;
      PAT_NADDR: data = ~DATA_W'(addr);
      default:   data = DATA_W'(addr);
    endcase
  end

endmodule

// File: rtl/flash_exerciser.sv
// Self-checking write/read-back traffic generator for the SPI flash request port.
module flash_exerciser
  import flash_exerciser_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned TIMEOUT_CYC = 2**20,
  parameter int unsigned ERR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [1:0]        pattern_sel,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [3:0]        state_code,
  output logic              flash_en,
  output logic              flash_write,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_data_in,
  input  logic [DATA_W-1:0] flash_data_out,
  input  logic              flash_ready
);

  localparam int unsigned      IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t            state;
  mode_t             mode_q;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   tcnt;
  logic              abort_pend;
  logic [DATA_W-1:0] rd_data;

  logic              gen_load;
  logic              gen_rewind;
  logic              gen_step;
  logic              ready_hit;
  logic              last_word;
  logic              stop_req;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] pat;

  assign cur_addr   = (ADDR_W'(BASE_ADDR) + (ADDR_W'(idx) << 2)) & ~ADDR_W'(3);
  assign last_word  = (idx == LAST_IDX);
  assign stop_req   = abort_pend | abort;
  assign state_code = state;

  // Pattern generator sequencing: load on start, rewind for verify, step per word
  always_comb begin
    ready_hit  = flash_en && flash_ready && (state == ST_WR || state == ST_RD);
    gen_load   = (state == ST_IDLE) && start;
    gen_rewind = (state == ST_WR) && ready_hit && last_word;
    gen_step   = ((state == ST_WR) && ready_hit && !last_word) || (state == ST_CHK);
  end

  flash_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pat (
    .clk    (clk),
    .reset  (reset),
    .load   (gen_load),
    .rewind (gen_rewind),
    .step   (gen_step),
    .sel    (pattern_sel),
    .seed   (seed),
    .addr   (cur_addr),
    .data   (pat)
  );

  // Run sequencer: request issue, completion/timeout handling, read-back check
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      mode_q         <= MODE_WV;
      idx            <= '0;
      tcnt           <= '0;
      abort_pend     <= 1'b0;
      rd_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_got  <= '0;
      first_err_exp  <= '0;
      flash_en       <= 1'b0;
      flash_write    <= 1'b0;
      flash_addr     <= '0;
      flash_data_in  <= '0;
    end else begin
      done <= 1'b0;
      if (busy) abort_pend <= abort_pend | abort;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_got  <= '0;
            first_err_exp  <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            idx            <= '0;
            abort_pend     <= abort;
            mode_q         <= mode_t'(mode);
            busy           <= 1'b1;
            state          <= (mode_t'(mode) == MODE_VERIFY) ? ST_RD : ST_WR;
          end
        end
        ST_WR, ST_RD: begin
          if (!flash_en) begin
            flash_en      <= 1'b1;
            flash_write   <= (state == ST_WR);
            flash_addr    <= cur_addr;
            flash_data_in <= (state == ST_WR) ? pat : '0;
            tcnt          <= '0;
          end else if (flash_ready) begin
            flash_en <= 1'b0;
            if (state == ST_RD) begin
              rd_data <= flash_data_out;
              state   <= ST_CHK;
            end else if (stop_req) begin
              state <= ST_DONE;
            end else if (last_word) begin
              idx   <= '0;
              state <= (mode_q == MODE_WRITE) ? ST_DONE : ST_RD;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else if (tcnt == TO_LAST) begin
            flash_en <= 1'b0;
            timeout  <= 1'b1;
            state    <= ST_DONE;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        ST_CHK: begin
          if (rd_data != pat) begin
            if (err_count == '0) begin
              first_err_addr <= cur_addr;
              first_err_got  <= rd_data;
              first_err_exp  <= pat;
            end
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
          end
          if (stop_req || last_word) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= ST_RD;
          end
        end
        ST_DONE: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          pass       <= (err_count == '0) && !timeout && !abort_pend;
          abort_pend <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_exerciser.sv
// Directed bench for flash_exerciser against a 3-cycle-latency flash model.
module tb_flash_exerciser;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ERR_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [1:0]        pattern_sel;
  logic [DATA_W-1:0] seed;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_got;
  logic [DATA_W-1:0] first_err_exp;
  logic [3:0]        state_code;
  logic              flash_en;
  logic              flash_write;
  logic [ADDR_W-1:0] flash_addr;
  logic [DATA_W-1:0] flash_data_in;
  logic [DATA_W-1:0] flash_data_out = '0;
  logic              flash_ready = 1'b0;

  int checks   = 0;
  int failures = 0;

  // flash model state
  logic              ready_on;
  logic              inject_ready;
  int                flip_idx;
  int                wcnt;
  int                n_wr;
  int                n_rd;
  logic [DATA_W-1:0] mem [16];
  logic [ADDR_W-1:0] wr_log [16];

  always #5 clk = ~clk;

  flash_exerciser #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_WORDS   (8),
    .BASE_ADDR   (0),
    .TIMEOUT_CYC (16),
    .ERR_W       (ERR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .pattern_sel    (pattern_sel),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_got  (first_err_got),
    .first_err_exp  (first_err_exp),
    .state_code     (state_code),
    .flash_en       (flash_en),
    .flash_write    (flash_write),
    .flash_addr     (flash_addr),
    .flash_data_in  (flash_data_in),
    .flash_data_out (flash_data_out),
    .flash_ready    (flash_ready)
  );

  // Flash model: ready on the third cycle of a request, optional bit-0 flip on one word
  always @(negedge clk) begin
    flash_ready = inject_ready;
    if (flash_en && ready_on) begin
      wcnt = wcnt + 1;
      if (wcnt == 3) begin
        wcnt = 0;
        flash_ready = 1'b1;
        if (flash_write) begin
          mem[flash_addr[5:2]] = flash_data_in;
          if (n_wr < 16) wr_log[n_wr] = flash_addr;
          n_wr = n_wr + 1;
        end else begin
          flash_data_out = mem[flash_addr[5:2]];
          if (int'(flash_addr[5:2]) == flip_idx) flash_data_out[0] = ~flash_data_out[0];
          n_rd = n_rd + 1;
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  psel;
    logic [31:0] seed;
    int          flip;
    int          ex_err;
    logic        ex_pass;
    logic [31:0] ex_addr;
    logic [31:0] ex_got;
    logic [31:0] ex_exp;
    int          ex_wr;
    int          ex_rd;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic [1:0] m, input logic [1:0] ps, input logic [31:0] sd,
                              input int fl, input int er, input logic ps_ok, input logic [31:0] ea,
                              input logic [31:0] eg, input logic [31:0] ee, input int wr, input int rd);
    vec_t v;
    v.mode = m; v.psel = ps; v.seed = sd; v.flip = fl; v.ex_err = er; v.ex_pass = ps_ok;
    v.ex_addr = ea; v.ex_got = eg; v.ex_exp = ee; v.ex_wr = wr; v.ex_rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    int c = 0;
    while (done !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_done"}, 64'(done), 64'(1));
  endtask

  task automatic run(input string name, input logic [1:0] m, input logic [1:0] ps,
                     input logic [31:0] sd, input logic ab);
    @(negedge clk);
    mode = m; pattern_sel = ps; seed = sd; abort = ab; start = 1'b1;
    n_wr = 0; n_rd = 0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk({name, "_busy"}, 64'(busy), 64'(1));
    chk({name, "_pass_clr"}, 64'(pass), 64'(0));
    wait_done(name, 1000);
  endtask

  task automatic rst_chk(input string name);
    chk({name, "_en"}, 64'(flash_en), 64'(0));
    chk({name, "_wr"}, 64'(flash_write), 64'(0));
    chk({name, "_addr"}, 64'(flash_addr), 64'(0));
    chk({name, "_din"}, 64'(flash_data_in), 64'(0));
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_done"}, 64'(done), 64'(0));
    chk({name, "_pass"}, 64'(pass), 64'(0));
    chk({name, "_tmo"}, 64'(timeout), 64'(0));
    chk({name, "_err"}, 64'(err_count), 64'(0));
    chk({name, "_ferr"}, 64'({first_err_addr, first_err_got, first_err_exp} != '0), 64'(0));
    chk({name, "_state"}, 64'(state_code), 64'(0));
  endtask

  initial begin
    int c;
    int en_cyc;
    string nm;

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; pattern_sel = 2'd0; seed = '0;
    ready_on = 1'b1; inject_ready = 1'b0; flip_idx = -1; wcnt = 0; n_wr = 0; n_rd = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      wr_log[i] = '0;
    end

    vecs[0]  = mk(2'd0, 2'd0, 32'h0,        -1, 0, 1'b1, 32'h0,  32'h0,        32'h0,        8, 8);
    vecs[1]  = mk(2'd0, 2'd0, 32'h0,         5, 1, 1'b0, 32'h14, 32'h15,       32'h14,       8, 8);
    vecs[2]  = mk(2'd2, 2'd2, 32'hA5A5A5A5, -1, 0, 1'b1, 32'h0,  32'h0,        32'h0,        8, 0);
    vecs[3]  = mk(2'd1, 2'd2, 32'hA5A5A5A5, -1, 0, 1'b1, 32'h0,  32'h0,        32'h0,        0, 8);
    vecs[4]  = mk(2'd0, 2'd3, 32'h0,         0, 1, 1'b0, 32'h0,  32'hFFFFFFFE, 32'hFFFFFFFF, 8, 8);
    vecs[5]  = mk(2'd0, 2'd1, 32'hDEADBEEF, -1, 0, 1'b1, 32'h0,  32'h0,        32'h0,        8, 8);
    vecs[6]  = mk(2'd1, 2'd1, 32'hDEADBEEF, -1, 0, 1'b1, 32'h0,  32'h0,        32'h0,        0, 8);
    vecs[7]  = mk(2'd2, 2'd1, 32'h1,        -1, 0, 1'b1, 32'h0,  32'h0,        32'h0,        8, 0);
    vecs[8]  = mk(2'd1, 2'd1, 32'h0,        -1, 0, 1'b1, 32'h0,  32'h0,        32'h0,        0, 8);
    vecs[9]  = mk(2'd1, 2'd1, 32'h2,        -1, 8, 1'b0, 32'h0,  32'h1,        32'h2,        0, 8);
    vecs[10] = mk(2'd3, 2'd0, 32'h0,        -1, 0, 1'b1, 32'h0,  32'h0,        32'h0,        8, 8);

    repeat (3) @(negedge clk);
    rst_chk("reset");
    reset = 1'b0;

    // table-driven runs
    for (int i = 0; i < 11; i++) begin
      nm = $sformatf("v%0d", i);
      flip_idx = vecs[i].flip;
      run(nm, vecs[i].mode, vecs[i].psel, vecs[i].seed, 1'b0);
      chk({nm, "_err"},  64'(err_count),      64'(vecs[i].ex_err));
      chk({nm, "_pass"}, 64'(pass),           64'(vecs[i].ex_pass));
      chk({nm, "_faddr"}, 64'(first_err_addr), 64'(vecs[i].ex_addr));
      chk({nm, "_fgot"}, 64'(first_err_got),  64'(vecs[i].ex_got));
      chk({nm, "_fexp"}, 64'(first_err_exp),  64'(vecs[i].ex_exp));
      chk({nm, "_nwr"},  64'(n_wr),           64'(vecs[i].ex_wr));
      chk({nm, "_nrd"},  64'(n_rd),           64'(vecs[i].ex_rd));
      chk({nm, "_tmo"},  64'(timeout),        64'(0));
      @(negedge clk);
      chk({nm, "_idle"}, 64'({busy, done, state_code}), 64'(0));
    end
    flip_idx = -1;

    // last table run used the address pattern: addresses and data are 4*k
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wlog%0d", k), 64'(wr_log[k]), 64'(4 * k));
      chk($sformatf("wmem%0d", k), 64'(mem[k]), 64'(4 * k));
    end

    // LFSR image from seed 0xDEADBEEF, first three words worked by hand
    run("lfsr_img", 2'd2, 2'd1, 32'hDEADBEEF, 1'b0);
    chk("lfsr_w0", 64'(mem[0]), 64'h0000_0000_DEAD_BEEF);
    chk("lfsr_w1", 64'(mem[1]), 64'h0000_0000_BD1B_7DD9);
    chk("lfsr_w2", 64'(mem[2]), 64'h0000_0000_7A76_FBB5);

    // timeout: no ready ever
    ready_on = 1'b0;
    @(negedge clk);
    mode = 2'd0; pattern_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en_cyc = 0; c = 0;
    while (done !== 1'b1 && c < 200) begin
      if (flash_en) en_cyc++;
      @(negedge clk);
      c++;
    end
    chk("tmo_done", 64'(done), 64'(1));
    chk("tmo_en_cycles", 64'(en_cyc), 64'(16));
    chk("tmo_flag", 64'(timeout), 64'(1));
    chk("tmo_pass", 64'(pass), 64'(0));
    chk("tmo_en_low", 64'(flash_en), 64'(0));
    chk("tmo_busy", 64'(busy), 64'(0));
    // late ready is ignored
    @(posedge clk); #1 inject_ready = 1'b1;
    @(posedge clk); #1 inject_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_rdy", 64'({busy, flash_en, state_code, err_count}), 64'(0));
    chk("late_tmo", 64'(timeout), 64'(1));
    ready_on = 1'b1;

    // abort during word 3 write
    @(negedge clk);
    mode = 2'd0; pattern_sel = 2'd0; start = 1'b1; n_wr = 0; n_rd = 0;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (n_wr < 3 && c < 200) begin @(negedge clk); c++; end
    while (flash_en && c < 200) begin @(negedge clk); c++; end
    while (!flash_en && c < 200) begin @(negedge clk); c++; end
    chk("abt_reach", 64'(c < 200), 64'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    c = 0;
    while (n_wr < 4 && c < 50) begin @(negedge clk); c++; end
    c = 0;
    while (done !== 1'b1 && c < 4) begin @(negedge clk); c++; end
    chk("abt_done_soon", 64'(done), 64'(1));
    chk("abt_pass", 64'(pass), 64'(0));
    repeat (8) @(negedge clk);
    chk("abt_nwr", 64'(n_wr), 64'(4));
    chk("abt_nrd", 64'(n_rd), 64'(0));
    chk("abt_idle", 64'({flash_en, busy}), 64'(0));

    // start and abort in the same cycle: one write then stop
    run("sabt", 2'd0, 2'd0, 32'h0, 1'b1);
    chk("sabt_pass", 64'(pass), 64'(0));
    chk("sabt_nwr", 64'(n_wr), 64'(1));
    chk("sabt_nrd", 64'(n_rd), 64'(0));

    // reset mid-read (word 2), then a clean run with a stray start mid-run
    @(negedge clk);
    mode = 2'd1; pattern_sel = 2'd0; start = 1'b1; n_wr = 0; n_rd = 0;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (n_rd < 2 && c < 200) begin @(negedge clk); c++; end
    while (flash_en && c < 200) begin @(negedge clk); c++; end
    while (!flash_en && c < 200) begin @(negedge clk); c++; end
    chk("rmid_reach", 64'({flash_en, flash_write, flash_addr}), 64'({1'b1, 1'b0, 24'h8}));
    reset = 1'b1;
    @(negedge clk);
    rst_chk("rmid");
    reset = 1'b0;
    @(negedge clk);
    mode = 2'd0; pattern_sel = 2'd0; start = 1'b1; n_wr = 0; n_rd = 0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("rerun", 1000);
    chk("rerun_pass", 64'(pass), 64'(1));
    chk("rerun_err", 64'(err_count), 64'(0));
    chk("rerun_nwr", 64'(n_wr), 64'(8));
    chk("rerun_nrd", 64'(n_rd), 64'(8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
